eggtimer_ctrl: RTL and testbench
================================

Name: eggtimer_ctrl

Overview:
- Sequencing FSM for the egg timer's cascaded BCD digit downcounters: MM:SS, four digits, digit 0 = seconds ones.
- Generates the shared counter load strobe and the per-digit decrement enables from a 1 Hz tick.
- Handles start/pause/clear buttons, detects 00:00 and drives the alarm with an optional auto-timeout.
- Sits between the debounced button/tick logic and the digit counter instances.

Parameters:
- DIGITS, 4, number of cascaded digit counters; digit 0 is least significant.
- ALARM_TIMEOUT, 60, ticks spent in DONE before an automatic reload; 0 = alarm holds until a button press; legal range 0..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse, 1 Hz.
- btn_start  in  1  one-cycle pulse, debounced; start/pause toggle.
- btn_clear  in  1  one-cycle pulse, debounced; abort and reload preset.
- digit_zero  in  DIGITS  per-digit "count == 0" flags from the counters.
- cnt_load  out  1  registered, active-high; drives each counter's async load/reset input (counters load start_count).
- digit_en  out  DIGITS  combinational per-digit decrement enables.
- running  out  1  registered; high in RUN.
- alarm  out  1  registered; alarm drive.

Behaviour:
- States: LOAD, IDLE, RUN, PAUSE, DONE. Encoding is free; state is not exported.
- Reset (reset_n low): state=LOAD, cnt_load=1, running=0, alarm=0, timeout counter=0. The counters are therefore held in load during reset.
- LOAD: lasts exactly 1 cycle with cnt_load=1, then goes to IDLE (cnt_load=0). cnt_load is high only in LOAD.
- all_zero = AND of digit_zero.
- IDLE:
  - btn_clear -> LOAD.
  - btn_start with !all_zero -> RUN.
  - btn_start with all_zero is ignored; stay in IDLE.
- RUN:
  - btn_clear -> LOAD.
  - all_zero -> DONE.
  - btn_start -> PAUSE.
  - Priority: clear > all_zero > start.
- PAUSE:
  - btn_clear -> LOAD.
  - btn_start -> RUN.
  - tick is ignored.
- DONE:
  - btn_clear or btn_start -> LOAD.
  - If ALARM_TIMEOUT != 0, count ticks in DONE; the tick that brings the count to ALARM_TIMEOUT moves the FSM to LOAD.
  - The timeout counter clears on entry to DONE.
- digit_en[0] = (state==RUN) & tick & !all_zero.
- digit_en[k] = digit_en[k-1] & digit_zero[k-1], for k = 1..DIGITS-1 (borrow ripple).
- The !all_zero gate guarantees no wrap 00:00 -> 59:59.
- Latency:
  - tick at edge N moves the counters 00:01 -> 00:00.
  - Edge N+1: state=DONE; alarm=1 and running=0 are visible after edge N+1.
- running/alarm are registered from the next state, so they change on the same edge as the state.
- tick coincident with btn_start in RUN: that tick's decrement is applied (enables derive from the current state), and the FSM enters PAUSE.
- tick coincident with btn_clear: the decrement is issued, but the load that follows overrides it.
- Simultaneous btn_start + btn_clear: clear wins in every state.
- reset_n asserted mid-RUN: immediate return to LOAD outputs; counters reload the preset.

Optional Feature:
- Macro: EGGTIMER_ALARM_BLINK_EN.
- Defined: in DONE, alarm=1 on entry and toggles on every tick while in DONE (0.5 Hz square wave).
- Undefined: alarm is steady 1 throughout DONE.
- In both cases alarm=0 in all other states.

Test Plan:
- Reset, preset 00:03, release reset:
  - cnt_load=1 for exactly 1 cycle after release, then IDLE.
  - btn_start -> running=1.
  - After 3 ticks the counters read 00:00.
  - Next cycle: alarm=1, running=0, digit_en stays 0 on further ticks.
- Preset 01:00, start, 1 tick:
  - digit_en=4'b0111 on that tick.
  - Counters read 00:59.
- Preset 00:10:
  - start, 2 ticks (00:08), btn_start -> PAUSE.
  - 5 ticks -> digit_en=0, count stays 00:08.
  - btn_start -> 2 more ticks -> 00:06.
- Preset 00:00:
  - btn_start -> stays IDLE, running=0, alarm=0.
- DONE with ALARM_TIMEOUT=3:
  - 3 ticks -> LOAD pulse, IDLE, alarm=0.
  - With EGGTIMER_ALARM_BLINK_EN, alarm sequence across those ticks is 1,0,1 before clearing.
- Mid-run events:
  - btn_start+btn_clear in the same cycle -> LOAD, then IDLE with preset restored.
  - reset_n pulse mid-RUN -> cnt_load=1 asynchronously, running=0.

Source files
------------

// File: rtl/eggtimer_ctrl.sv
// ============================================================================
// eggtimer_ctrl : sequencing FSM for the egg timer's cascaded BCD downcounters.
// Optional macro EGGTIMER_ALARM_BLINK_EN: alarm toggles on every tick in DONE.
// Rev 1.0
// ============================================================================
`default_nettype none

module eggtimer_ctrl #(
  parameter int DIGITS        = 4,
  parameter int ALARM_TIMEOUT = 60
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              btn_start,
  input  logic              btn_clear,
  input  logic [DIGITS-1:0] digit_zero,
  output logic              cnt_load,
  output logic [DIGITS-1:0] digit_en,
  output logic              running,
  output logic              alarm
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(ALARM_TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tcnt;
  logic       r_cnt_load;
  logic       r_running;
  logic       r_alarm;
  logic       w_alarm_nxt;
  logic       w_all_zero;
  logic       w_timeout;
  logic       w_en0;

  assign w_all_zero = &digit_zero;
  assign w_timeout  = (ALARM_TIMEOUT != 0) && tick && ((r_tcnt + 8'd1) == C_TIMEOUT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  w_next = S_IDLE;
      S_IDLE: begin
        if (btn_clear)                     w_next = S_LOAD;
        else if (btn_start && !w_all_zero) w_next = S_RUN;
      end
      S_RUN: begin
        if (btn_clear)       w_next = S_LOAD;
        else if (w_all_zero) w_next = S_DONE;
        else if (btn_start)  w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (btn_clear)      w_next = S_LOAD;
        else if (btn_start) w_next = S_RUN;
      end
      S_DONE: begin
        if (btn_clear || btn_start || w_timeout) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

`ifdef EGGTIMER_ALARM_BLINK_EN
  // High on entry to DONE, then one toggle per tick while staying there.
  always_comb begin
    w_alarm_nxt = 1'b0;
    if (w_next == S_DONE) begin
      if (r_state != S_DONE) w_alarm_nxt = 1'b1;
      else                   w_alarm_nxt = tick ? ~r_alarm : r_alarm;
    end
  end
`else
  always_comb begin
    w_alarm_nxt = (w_next == S_DONE);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_LOAD;
      r_cnt_load <= 1'b1;
      r_running  <= 1'b0;
      r_alarm    <= 1'b0;
      r_tcnt     <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_cnt_load <= (w_next == S_LOAD);
      r_running  <= (w_next == S_RUN);
      r_alarm    <= w_alarm_nxt;
      // Held at zero outside DONE, so every entry starts a fresh count.
      if (r_state != S_DONE) r_tcnt <= 8'd0;
      else if (tick)         r_tcnt <= r_tcnt + 8'd1;
    end
  end

  // Borrow ripple written as a flat AND of lower zero flags.
  assign w_en0       = (r_state == S_RUN) && tick && !w_all_zero;
  assign digit_en[0] = w_en0;

  generate
    for (genvar k = 1; k < DIGITS; k++) begin : g_borrow
      assign digit_en[k] = w_en0 & (&digit_zero[k-1:0]);
    end
  endgenerate

  assign cnt_load = r_cnt_load;
  assign running  = r_running;
  assign alarm    = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_eggtimer_ctrl.sv
// ============================================================================
// tb_eggtimer_ctrl : bench with BCD counter fixture and seconds-level model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_eggtimer_ctrl;

  localparam int TO = 3;
  localparam int M_LOAD = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
`ifdef EGGTIMER_ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] digit_zero;
  logic       cnt_load;
  logic [3:0] digit_en;
  logic       running;
  logic       alarm;

  logic [3:0] pre [4];
  logic [3:0] cnt [4];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         place [4] = '{1, 10, 60, 600};
  int         maxd  [4] = '{9, 5, 9, 9};

  eggtimer_ctrl #(.DIGITS(4), .ALARM_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btn_start(btn_start),
    .btn_clear(btn_clear), .digit_zero(digit_zero), .cnt_load(cnt_load),
    .digit_en(digit_en), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Digit counters the controller drives: async load, decrement with borrow wrap.
  always @(posedge clk or posedge cnt_load) begin
    if (cnt_load) begin
      for (int k = 0; k < 4; k++) cnt[k] <= pre[k];
    end else begin
      for (int k = 0; k < 4; k++)
        if (digit_en[k]) cnt[k] <= (cnt[k] == 4'd0) ? 4'(maxd[k]) : cnt[k] - 4'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) digit_zero[k] = (cnt[k] == 4'd0);
  end

  function automatic int cnt_secs();
    return int'(cnt[3]) * 600 + int'(cnt[2]) * 60 + int'(cnt[1]) * 10 + int'(cnt[0]);
  endfunction

  function automatic int pre_secs();
    return int'(pre[3]) * 600 + int'(pre[2]) * 60 + int'(pre[1]) * 10 + int'(pre[0]);
  endfunction

  task automatic set_preset(input int s);
    int m, ss;
    m = s / 60;
    ss = s % 60;
    pre[0] = 4'(ss % 10);
    pre[1] = 4'(ss / 10);
    pre[2] = 4'(m % 10);
    pre[3] = 4'(m / 10);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remaining time as plain seconds plus the current mode.
  int m_mode, m_secs, m_tcnt, m_nm;
  bit m_phase, m_az;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_LOAD;
      m_secs = pre_secs();
      m_tcnt = 0;
      m_phase = 1'b0;
    end else begin
      m_nm = m_mode;
      m_az = (m_secs == 0);
      if (m_mode == M_RUN && tick && !m_az) m_secs = m_secs - 1;
      case (m_mode)
        M_LOAD:  m_nm = M_IDLE;
        M_IDLE:  if (btn_clear) m_nm = M_LOAD; else if (btn_start && !m_az) m_nm = M_RUN;
        M_RUN:   if (btn_clear) m_nm = M_LOAD; else if (m_az) m_nm = M_DONE;
                 else if (btn_start) m_nm = M_PAUSE;
        M_PAUSE: if (btn_clear) m_nm = M_LOAD; else if (btn_start) m_nm = M_RUN;
        default: begin
          if (btn_clear || btn_start) m_nm = M_LOAD;
          else if (tick) begin
            m_phase = ~m_phase;
            m_tcnt = m_tcnt + 1;
            if (TO != 0 && m_tcnt == TO) m_nm = M_LOAD;
          end
        end
      endcase
      if (m_nm == M_DONE && m_mode != M_DONE) begin
        m_tcnt = 0;
        m_phase = 1'b1;
      end
      if (m_nm == M_LOAD) m_secs = pre_secs();
      m_mode = m_nm;
    end
  end

  logic [3:0] exp_en;
  always @(negedge clk) begin
    exp_en = 4'd0;
    if (m_mode == M_RUN && tick && m_secs > 0)
      for (int k = 0; k < 4; k++) if (m_secs % place[k] == 0) exp_en[k] = 1'b1;
    chk("cnt_load", cnt_load, m_mode == M_LOAD);
    chk("running", running, m_mode == M_RUN);
    chk("alarm", alarm, (m_mode == M_DONE) && (BLINK ? m_phase : 1'b1));
    chk("digit_en", digit_en, exp_en);
    chk("count", cnt_secs(), m_secs);
  end

  // All stepping tasks start and end at posedge+2.
  task automatic step(input logic t, input logic s, input logic c);
    tick = t; btn_start = s; btn_clear = c;
    @(posedge clk); #2;
    tick = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
  endtask

  task automatic tick_chk(input string nm, input logic [3:0] e);
    tick = 1'b1;
    #1 chk(nm, digit_en, e);
    @(posedge clk); #2;
    tick = 1'b0;
  endtask

  task automatic reload(input int s);
    set_preset(s);
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  int r;
  initial begin
    set_preset(3);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    chk("reset_load", cnt_load, 1'b1);
    chk("reset_alarm", alarm, 1'b0);
    step(0, 0, 0);
    chk("load_one_cycle", cnt_load, 1'b0);
    step(0, 1, 0);
    chk("start_running", running, 1'b1);
    repeat (3) step(1, 0, 0);
    chk("at_zero", cnt_secs(), 0);
    chk("at_zero_run", running, 1'b1);
    step(0, 0, 0);
    chk("done_alarm", alarm, 1'b1);
    chk("done_running", running, 1'b0);
    tick_chk("done_no_en", 4'd0);
    chk("blink_t1", alarm, BLINK ? 1'b0 : 1'b1);
    step(1, 0, 0);
    chk("blink_t2", alarm, 1'b1);
    step(1, 0, 0);
    chk("timeout_load", cnt_load, 1'b1);
    chk("timeout_alarm", alarm, 1'b0);
    step(0, 0, 0);
    chk("timeout_idle", cnt_load, 1'b0);
    chk("timeout_preset", cnt_secs(), 3);

    reload(60);
    step(0, 1, 0);
    tick_chk("borrow_0111", 4'b0111);
    chk("count_0059", {cnt[3], cnt[2], cnt[1], cnt[0]}, 16'h0059);

    reload(10);
    step(0, 1, 0);
    repeat (2) step(1, 0, 0);
    chk("count_08", cnt_secs(), 8);
    step(0, 1, 0);
    chk("pause_running", running, 1'b0);
    repeat (5) tick_chk("pause_no_en", 4'd0);
    chk("pause_hold", cnt_secs(), 8);
    step(0, 1, 0);
    repeat (2) step(1, 0, 0);
    chk("resume_06", cnt_secs(), 6);

    reload(0);
    step(0, 1, 0);
    chk("zero_start_run", running, 1'b0);
    chk("zero_start_alarm", alarm, 1'b0);
    chk("zero_start_load", cnt_load, 1'b0);

    reload(5);
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 1);
    chk("both_btn_load", cnt_load, 1'b1);
    step(0, 0, 0);
    chk("both_btn_preset", cnt_secs(), 5);
    chk("both_btn_idle", running, 1'b0);

    step(0, 1, 0);
    step(1, 0, 0);
    reset_n = 1'b0;
    #1 chk("async_rst_load", cnt_load, 1'b1);
    chk("async_rst_run", running, 1'b0);
    chk("async_rst_preset", cnt_secs(), 5);
    @(posedge clk); #2 reset_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      if (cnt_load == 1'b0 && ($urandom % 40) == 0) begin
        r = $urandom % 8;
        set_preset(r < 6 ? $urandom_range(0, 12) : $urandom_range(55, 130));
      end
      if (($urandom % 700) == 0) reset_n = 1'b0;
      step(($urandom % 4) == 0, ($urandom % 12) == 0, ($urandom % 50) == 0);
      reset_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
